// File: rtl/mod_counter_hex.sv
// rtl/mod_counter_hex.sv - modulo up/down counter with load, tc/wrap flags and per-nibble 7-segment decode
// Count range is 0..MAX; loads above MAX clamp to MAX.
module mod_counter_hex #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     up,
  input  logic                     load,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         q,
  output logic                     tc,
  output logic                     wrap,
  output logic [7*(WIDTH/4)-1:0]   hex
);

  localparam int D = WIDTH / 4;
  localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = (din > MAX_V) ? MAX_V : din;
    end else if (en) begin
      if (up) begin
        if (q_q == MAX_V) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if (q_q == '0) begin
          q_d    = MAX_V;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  // tc deliberately ignores load so it flags the would-be wrap from en/up alone.
  assign tc   = en & ((up & (q_q == MAX_V)) | (~up & (q_q == '0)));
  assign q    = q_q;
  assign wrap = wrap_q;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  for (genvar i = 0; i < D; i++) begin : g_digit
    assign hex[7*i +: 7] = seg7(q_q[4*i +: 4]);
  end

endmodule

// File: tb/tb_mod_counter_hex.sv
// tb/tb_mod_counter_hex.sv - directed table-driven bench for mod_counter_hex
// Three instances share stimulus: 8-bit MAX=59, 4-bit MAX=15, 8-bit MAX=255.
module tb_mod_counter_hex;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic        load = 1'b0;
  logic [7:0]  din = 8'h00;

  logic [7:0]  q59, qd;
  logic [3:0]  q4;
  logic        tc59, tc4, tcd;
  logic        wrap59, wrap4, wrapd;
  logic [13:0] hex59, hexd;
  logic [6:0]  hex4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [16];

  mod_counter_hex #(.WIDTH(8), .MAX(59)) u_dut59 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(q59), .tc(tc59), .wrap(wrap59), .hex(hex59)
  );

  mod_counter_hex #(.WIDTH(4), .MAX(15)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din[3:0]),
    .q(q4), .tc(tc4), .wrap(wrap4), .hex(hex4)
  );

  mod_counter_hex #(.WIDTH(8), .MAX(255)) u_dutd (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(qd), .tc(tcd), .wrap(wrapd), .hex(hexd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       load;
    logic       en;
    logic       up;
    logic [7:0] din;
    logic [7:0] q;
    logic       wrap;
    logic       tc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic l, input logic e, input logic u, input logic [7:0] d,
                              input logic [7:0] eq, input logic ew, input logic et);
    vec_t v;
    v.load = l; v.en = e; v.up = u; v.din = d; v.q = eq; v.wrap = ew; v.tc = et;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic l, input logic e, input logic u, input logic [7:0] d);
    @(negedge clk);
    load = l; en = e; up = u; din = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic e, input logic u);
    @(negedge clk);
    rst = 1'b0; load = 1'b0; en = e; up = u; din = 8'h00;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
    seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;

    // Sequential vectors for the MAX=59 instance; tc is sampled before the edge.
    vecs.push_back(mk(1, 1, 1, 8'h20, 8'h20, 0, 0));
    vecs.push_back(mk(1, 0, 1, 8'hFF, 8'h3B, 0, 0));
    vecs.push_back(mk(1, 0, 1, 8'h12, 8'h12, 0, 0));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 0, 1, 8'h00, 8'h12, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h00, 8'h13, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h12, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h00, 8'h13, 0, 0));
    vecs.push_back(mk(1, 0, 1, 8'h3B, 8'h3B, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h00, 8'h00, 1, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h3B, 1, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h3A, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h3A, 0, 0));
    vecs.push_back(mk(1, 1, 1, 8'h3B, 8'h3B, 0, 0));
    vecs.push_back(mk(1, 1, 1, 8'h10, 8'h10, 0, 1));
    vecs.push_back(mk(1, 0, 1, 8'h3C, 8'h3B, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0));

    // Reset state, including tc = en & ~up while held in reset.
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", 32'(q59), 0);
    check("reset_wrap", 32'(wrap59), 0);
    check("reset_hex", 32'(hex59), 32'h2040);
    check("reset_tc_idle", 32'(tc59), 0);
    en = 1'b1; up = 1'b0;
    #1;
    check("reset_tc_down", 32'(tc59), 1);
    en = 1'b0; up = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].din);
      #1;
      check($sformatf("vec%0d_tc", i), 32'(tc59), 32'(vecs[i].tc));
      tick();
      check($sformatf("vec%0d_q", i), 32'(q59), 32'(vecs[i].q));
      check($sformatf("vec%0d_wrap", i), 32'(wrap59), 32'(vecs[i].wrap));
    end

    // Up-wrap from 0 with MAX=59.
    do_reset(1, 1);
    repeat (59) @(posedge clk);
    #1;
    check("upwrap_q59", 32'(q59), 59);
    check("upwrap_tc", 32'(tc59), 1);
    check("upwrap_hex_3b", 32'(hex59), 32'({7'b0110000, 7'b0000011}));
    tick();
    check("upwrap_q0", 32'(q59), 0);
    check("upwrap_wrap1", 32'(wrap59), 1);
    tick();
    check("upwrap_q1", 32'(q59), 1);
    check("upwrap_wrap0", 32'(wrap59), 0);

    // Down-wrap from 0.
    do_reset(1, 0);
    #1;
    check("downwrap_tc", 32'(tc59), 1);
    tick();
    check("downwrap_q59", 32'(q59), 59);
    check("downwrap_wrap1", 32'(wrap59), 1);
    tick();
    check("downwrap_q58", 32'(q59), 58);
    check("downwrap_wrap0", 32'(wrap59), 0);

    // Async reset mid-count with a wrap pulse pending and the 255 instance at 0x5A.
    drive(1, 0, 1, 8'h59);
    tick();
    drive(0, 1, 1, 8'h00);
    tick();
    check("pre_rst_qd", 32'(qd), 32'h5A);
    check("pre_rst_wrap", 32'(wrap59), 1);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_qd", 32'(qd), 0);
    check("async_rst_hexd", 32'(hexd), 32'h2040);
    check("async_rst_q59", 32'(q59), 0);
    check("async_rst_wrap", 32'(wrap59), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("first_count_q59", 32'(q59), 1);
    check("first_count_qd", 32'(qd), 1);

    // Full hex range on the 4-bit instance.
    do_reset(1, 1);
    #1;
    check("hex4_start", 32'(hex4), 32'(seg_tab[0]));
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("full_q4_%0d", k), 32'(q4), 32'(k % 16));
      check($sformatf("full_hex4_%0d", k), 32'(hex4), 32'(seg_tab[k % 16]));
      check($sformatf("full_wrap4_%0d", k), 32'(wrap4), (k == 16) ? 1 : 0);
    end
    tick();
    check("full_wrap4_fall", 32'(wrap4), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_counter_hex.md
# mod_counter_hex

Parametrised modulo up/down counter with synchronous load, terminal-count and wrap flags, and per-nibble seven-segment decode. It generalises the board's 4-bit toggle-flip-flop counter to any multiple-of-4 width, a programmable modulus and selectable direction. It drives the HEXn displays directly; any board key used as a count request must be synchronised and edge-detected upstream.

## Interface
Parameters:
- WIDTH, 8, counter width in bits; multiple of 4, range 4..16; number of display digits D = WIDTH/4
- MAX, 255, terminal value; counter range is 0..MAX; 1 ≤ MAX ≤ 2^WIDTH−1

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset: asynchronous, active-low
- en  in  1  count enable, sampled each clock
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  synchronous load of din; has priority over en
- din  in  WIDTH  load value
- q  out  WIDTH  current count, registered
- tc  out  1  terminal count, combinational: en & ((up & q==MAX) | (~up & q==0))
- wrap  out  1  registered one-cycle pulse, set in the cycle after a wrap occurs
- hex  out  7*D  active-low segments; digit i = hex[7i+6:7i] decodes q[4i+3:4i]; bit order g f e d c b a (MSB..LSB)

## Operation
- Priority per rising edge: rst (async) > load > en > hold.
- load=1: q ← din if din ≤ MAX, else q ← MAX (clamp). wrap ← 0. en and up are ignored that cycle.
- en=1, up=1: q ← q+1 if q < MAX; q ← 0 and wrap ← 1 if q == MAX.
- en=1, up=0: q ← q−1 if q > 0; q ← MAX and wrap ← 1 if q == 0.
- en=0 and load=0: q holds, wrap ← 0.
- wrap is 1 for exactly one cycle per wrap event. Consecutive wrap cycles (e.g. MAX=1 with en held high) give consecutive 1s.
- Out-of-range q (> MAX) is unreachable. Any load above MAX is clamped.
- Arithmetic is performed in WIDTH bits. No carry is exposed beyond tc and wrap.
- Segment decode, hex digit to gfedcba (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Digits are decoded from raw binary nibbles, not BCD.

## Timing
- Reset values: q=0, wrap=0. hex shows '0' on every digit (1000000 per digit). tc = en & ~up while in reset.
- Assertion of rst clears state immediately, independent of clk. Deassertion is synchronous to the next rising edge; the first count occurs on the first edge with rst high.
- Count latency: q changes on the rising edge where en=1. hex follows q combinationally in the same cycle.
- tc is valid in the cycle before the wrapping edge. wrap rises on the wrapping edge and falls on the next edge unless another wrap occurs.
- A direction change takes effect on the same edge it is sampled. There is no pipeline.
- Simultaneous load and en: the load wins, with no count and no wrap.
- Reset mid-count: q returns to 0 and any pending wrap pulse is cleared.

## Test plan
- Reset: drive rst=0 with q previously at 0x5A → q=0x00, wrap=0, hex = 1000000_1000000, asynchronously, without a clock edge.
- Up-wrap, WIDTH=8, MAX=59, up=1, en=1 from 0:
  - After 59 edges q=59 (0x3B) and tc=1; hex digits '3','b' = 0110000, 0000011.
  - On the next edge q=0 and wrap=1 for one cycle.
- Down-wrap, MAX=59, up=0, en=1 from q=0: tc=1 → next edge q=59, wrap=1 → next edge q=58, wrap=0.
- Load priority and clamp:
  - load=1, en=1, din=0x20 → q=0x20, wrap=0.
  - load=1, din=0xFF with MAX=59 → q=59.
- Hold and direction flip:
  - en=0 for 10 cycles at q=0x12 → q stays 0x12, wrap=0.
  - Then en=1, up toggled each cycle → q alternates 0x13, 0x12, 0x13.
- Full range, WIDTH=4, MAX=15: up-count of 16 edges passes through every hex pattern 0..F in order, and wraps to 0 with wrap=1.
